// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset constants and next-PC select encoding for the fetch stage.
package fetch_unit_pkg;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 16;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam addr_t  RESET_VECTOR = 10'd0;
    localparam instr_t NOP_WORD     = 16'h0000;

    // Which source feeds the PC on the coming edge
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RET,
        SEL_RET_ERR,
        SEL_CALL,
        SEL_JUMP,
        SEL_SEQ
    } pc_sel_e;

    // Sequential successor; the 10-bit add wraps 1023 -> 0 naturally
    function automatic addr_t pc_inc(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_unit_ret_stack.sv
// Return-address LIFO. Overflowing pushes and underflowing pops are dropped;
// the caller decides whether that is an error.
module ret_stack
    import fetch_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  addr_t din,
    output addr_t dout,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = $clog2(STACK_DEPTH);

    // sp counts 0..STACK_DEPTH, so it needs one bit more than the entry index
    logic [PTR_W:0]   sp;
    logic [PTR_W-1:0] top_idx;
    addr_t            mem [STACK_DEPTH];

    assign full    = (sp == (PTR_W+1)'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = PTR_W'(sp - (PTR_W+1)'(1));
    assign dout    = mem[top_idx];

    // Pointer moves only on accepted operations; push wins if both are asked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            sp <= sp - (PTR_W+1)'(1);
        end
    end

    // Entry storage; contents are meaningless once sp is reset
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC priority mux, instruction register
// with bubble flag, and return-stack control for call/return.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  Data,
    input  logic                stall,
    input  logic                s_jump,
    input  logic                s_call,
    input  logic                s_ret,
    input  logic [ADDR_W-1:0]   target,
    output logic [ADDR_W-1:0]   Address,
    output logic [INSTR_W-1:0]  Instr,
    output logic                Instr_valid,
    output logic                stack_err
);

    addr_t   pc;
    addr_t   next_pc;
    addr_t   stack_top;
    pc_sel_e sel;
    logic    stack_full;
    logic    stack_empty;
    logic    redirect;
    logic    err_set;

    assign Address = pc;

    // Priority decode: stall beats return beats call beats jump
    always_comb begin
        sel = SEL_SEQ;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (s_ret) begin
            sel = stack_empty ? SEL_RET_ERR : SEL_RET;
        end else if (s_call) begin
            sel = SEL_CALL;
        end else if (s_jump) begin
            sel = SEL_JUMP;
        end
    end

    // Next-PC source; a failed return falls through to sequential fetch
    always_comb begin
        next_pc = pc_inc(pc);
        case (sel)
            SEL_HOLD:           next_pc = pc;
            SEL_RET:            next_pc = stack_top;
            SEL_CALL, SEL_JUMP: next_pc = target;
            default:            next_pc = pc_inc(pc);
        endcase
    end

    assign redirect = (sel == SEL_RET) || (sel == SEL_CALL) || (sel == SEL_JUMP);
    assign err_set  = (sel == SEL_RET_ERR) || ((sel == SEL_CALL) && stack_full);

    // The call instruction sits at pc-1, so pc is already the return address
    ret_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (sel == SEL_CALL),
        .pop   (sel == SEL_RET),
        .din   (pc),
        .dout  (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Fetch state: the word at the old PC is always captured, but a redirect marks it a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_VECTOR;
            Instr       <= NOP_WORD;
            Instr_valid <= 1'b0;
            stack_err   <= 1'b0;
        end else if (sel != SEL_HOLD) begin
            pc          <= next_pc;
            Instr       <= Data;
            Instr_valid <= !redirect;
            if (err_set) begin
                stack_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus runs a queue-based reference model
// and queues the expected post-edge state; a monitor pops and compares.
module tb_fetch_unit;

    localparam int DEPTH = 8;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] instr;
        logic        valid;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] Data;
    logic        stall = 1'b0;
    logic        s_jump = 1'b0;
    logic        s_call = 1'b0;
    logic        s_ret = 1'b0;
    logic [9:0]  target = '0;
    logic [9:0]  Address;
    logic [15:0] Instr;
    logic        Instr_valid;
    logic        stack_err;

    logic [15:0] mem [1024];
    assign Data = mem[Address];

    fetch_unit #(.STACK_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .Data        (Data),
        .stall       (stall),
        .s_jump      (s_jump),
        .s_call      (s_call),
        .s_ret       (s_ret),
        .target      (target),
        .Address     (Address),
        .Instr       (Instr),
        .Instr_valid (Instr_valid),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // reference model state
    int          m_pc;
    int          m_stack[$];
    bit          m_err;
    logic [15:0] m_instr;
    bit          m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_err = 0;
        m_instr = 16'h0000;
        m_valid = 0;
    endtask

    // Drive one cycle of control, advance the model, queue the expected result
    task automatic cyc(input bit st, input bit j, input bit c, input bit r, input int tg);
        exp_t e;
        stall = st; s_jump = j; s_call = c; s_ret = r; target = tg[9:0];
        if (!st) begin
            m_instr = mem[m_pc];
            if (r && m_stack.size() > 0) begin
                m_pc = m_stack.pop_back();
                m_valid = 0;
            end else if (r) begin
                m_err = 1;
                m_pc = (m_pc + 1) % 1024;
                m_valid = 1;
            end else if (c) begin
                if (m_stack.size() < DEPTH) m_stack.push_back(m_pc);
                else m_err = 1;
                m_pc = tg % 1024;
                m_valid = 0;
            end else if (j) begin
                m_pc = tg % 1024;
                m_valid = 0;
            end else begin
                m_pc = (m_pc + 1) % 1024;
                m_valid = 1;
            end
        end
        e.addr = m_pc[9:0]; e.instr = m_instr; e.valid = m_valid; e.err = m_err;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every queued expectation just after its clock edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("address", Address, e.addr);
                chk("instr", Instr, e.instr);
                chk("instr_valid", Instr_valid, e.valid);
                chk("stack_err", stack_err, e.err);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 16'h100);
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_address", Address, 0);
        chk("reset_instr", Instr, 0);
        chk("reset_valid", Instr_valid, 0);
        chk("reset_err", stack_err, 0);
        reset = 1'b1;

        // sequential fetch from reset, then jump flush
        repeat (4) idle();
        chk("seq_addr4", Address, 4);
        chk("seq_instr3", Instr, 16'h103);
        cyc(0, 1, 0, 0, 500);
        chk("jump_bubble", Instr_valid, 0);
        idle();
        chk("jump_addr", Address, 501);
        chk("jump_instr", Instr, 16'h2F4);
        chk("jump_valid", Instr_valid, 1);

        // nested call/return
        cyc(0, 1, 0, 0, 5); idle();
        cyc(0, 0, 1, 0, 100);
        repeat (3) idle();
        cyc(0, 0, 1, 0, 200); idle();
        cyc(0, 0, 0, 1, 0);
        chk("ret1_addr", Address, 103);
        chk("ret1_bubble", Instr_valid, 0);
        idle();
        cyc(0, 0, 0, 1, 0); idle();
        chk("nested_err", stack_err, 0);

        // overflow, LIFO drain, underflow
        for (int k = 0; k < 9; k++) begin
            cyc(0, 0, 1, 0, 300 + 10 * k);
            if (k < 8) idle();
        end
        chk("ovf_err", stack_err, 1);
        chk("ovf_jump_taken", Address, 380);
        idle();
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 1, 0); idle();
        end
        cyc(0, 0, 0, 1, 0);
        chk("unf_valid", Instr_valid, 1);
        idle();
        chk("unf_err_sticky", stack_err, 1);

        // stall with a jump request, then PC wraparound
        repeat (3) cyc(1, 1, 0, 0, 700);
        idle();
        cyc(0, 1, 0, 0, 1022); idle(); idle();
        chk("wrap_addr", Address, 0);

        // asynchronous reset with three stack entries
        cyc(0, 0, 1, 0, 50); idle();
        cyc(0, 0, 1, 0, 60); idle();
        cyc(0, 0, 1, 0, 70); idle();
        stall = 0; s_jump = 0; s_call = 0; s_ret = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_address", Address, 0);
        chk("async_instr", Instr, 0);
        chk("async_valid", Instr_valid, 0);
        chk("async_err", stack_err, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle();
        chk("post_rst_instr", Instr, 16'h100);
        chk("post_rst_valid", Instr_valid, 1);
        cyc(0, 0, 0, 1, 0);
        chk("post_rst_ret_err", stack_err, 1);
        idle();

        // randomized traffic over random memory contents
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                int'($urandom_range(0, 1023)));
        end
        idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
